// File: rtl/seq_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (a - b - bi), CHUNK bits per clock with a registered borrow chain.
// Optional signed-overflow flag enabled by defining SEQ_SUBTRACTOR_OVF_EN.
module seq_subtractor #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned LAST   = NCHUNK - 1;

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_subtractor: WIDTH must be a non-zero integer multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bo_q, bo_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CHUNK:0]     sub_c;

`ifdef SEQ_SUBTRACTOR_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            bo_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            bo_q        <= bo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SEQ_SUBTRACTOR_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end
`endif

    // Next-state: operands shift right one chunk per RUN cycle, results enter diff from the top
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        bo_d        = bo_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_SUBTRACTOR_OVF_EN
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        ovf_d       = ovf_q;
`endif
        sub_c = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - (CHUNK+1)'(borrow_q);

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    borrow_d   = bi;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
`ifdef SEQ_SUBTRACTOR_OVF_EN
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                diff_d   = (diff_q >> CHUNK) | (WIDTH'(sub_c[CHUNK-1:0]) << (WIDTH - CHUNK));
                borrow_d = sub_c[CHUNK];
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(LAST)) begin
                    idx_d       = '0;
                    bo_d        = sub_c[CHUNK];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`ifdef SEQ_SUBTRACTOR_OVF_EN
                    // Top chunk's MSB is the result sign bit
                    ovf_d       = (a_msb_q != b_msb_q) && (sub_c[CHUNK-1] != a_msb_q);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bo        = bo_q;
`ifdef SEQ_SUBTRACTOR_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule
